// File: rtl/alu_to_mem.sv
// alu_to_mem: EX->MEM pipeline register capturing ALU-stage control, destination, result and store data.
module alu_to_mem #(
  parameter int DATA_W = 24,
  parameter int DEST_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              writeback_enable,
  input  logic              mem_read_enable,
  input  logic              mem_write_enable,
  input  logic [DEST_W-1:0] instruction_dest,
  input  logic [DATA_W-1:0] alu_result,
  input  logic [DATA_W-1:0] write_data,
  output logic              writeback_enable_out,
  output logic              mem_read_enable_out,
  output logic              mem_write_enable_out,
  output logic [DEST_W-1:0] instruction_dest_out,
  output logic [DATA_W-1:0] alu_result_out,
  output logic [DATA_W-1:0] write_data_out
);
  localparam int W = 3 + DEST_W + 2 * DATA_W;
  // Power-up value of zero makes the outputs a bubble even before any reset.
  logic [W-1:0] stage_q = '0;
  logic [W-1:0] stage_d;
  always_comb begin
    stage_d = rst ? '0 : {writeback_enable, mem_read_enable, mem_write_enable,
                          instruction_dest, alu_result, write_data};
  end
  always_ff @(posedge clk) begin
    stage_q <= stage_d;
  end
  assign {writeback_enable_out, mem_read_enable_out, mem_write_enable_out,
          instruction_dest_out, alu_result_out, write_data_out} = stage_q;
endmodule

// File: tb/tb_alu_to_mem.sv
// tb_alu_to_mem: directed scoreboard bench for the EX->MEM pipeline register.
module tb_alu_to_mem;
  typedef struct packed {
    logic        wb;
    logic        rd;
    logic        wr;
    logic [3:0]  dest;
    logic [23:0] alu;
    logic [23:0] wd;
  } stage_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        wb = 1'b0, rd = 1'b0, wr = 1'b0;
  logic [3:0]  dest = '0;
  logic [23:0] alu = '0, wd = '0;
  logic        wb_o, rd_o, wr_o;
  logic [3:0]  dest_o;
  logic [23:0] alu_o, wd_o;
  stage_t      obs, last;
  stage_t      sb[$];
  int          errors = 0;
  int          checks = 0;

  alu_to_mem #(.DATA_W(24), .DEST_W(4)) dut (
    .clk(clk), .rst(rst),
    .writeback_enable(wb), .mem_read_enable(rd), .mem_write_enable(wr),
    .instruction_dest(dest), .alu_result(alu), .write_data(wd),
    .writeback_enable_out(wb_o), .mem_read_enable_out(rd_o), .mem_write_enable_out(wr_o),
    .instruction_dest_out(dest_o), .alu_result_out(alu_o), .write_data_out(wd_o)
  );

  always #10 clk = ~clk;

  assign obs = '{wb: wb_o, rd: rd_o, wr: wr_o, dest: dest_o, alu: alu_o, wd: wd_o};

  task automatic check(input string tag, input stage_t exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Called at edge-1: drive, confirm hold, cross the edge, compare at edge+1, return at next edge-1.
  task automatic step(input string tag, input logic r, input logic w, input logic d_rd,
                      input logic d_wr, input logic [3:0] d, input logic [23:0] a,
                      input logic [23:0] dw);
    rst = r; wb = w; rd = d_rd; wr = d_wr; dest = d; alu = a; wd = dw;
    sb.push_back(r ? stage_t'('0) : stage_t'{w, d_rd, d_wr, d, a, dw});
    #0 check({tag, "_hold"}, last);
    @(posedge clk);
    #1;
    last = sb.pop_front();
    check(tag, last);
    #18;
  endtask

  initial begin
    last = '0;
    #1 check("powerup", last);
    #8;
    step("idle", 1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 24'h0, 24'h0);
    step("capture", 1'b0, 1'b1, 1'b1, 1'b1, 4'h2, 24'd5, 24'd10);
    step("update", 1'b0, 1'b0, 1'b0, 1'b0, 4'h1, 24'd3, 24'd4);
    for (int i = 0; i < 5; i++) step("update_hold", 1'b0, 1'b0, 1'b0, 1'b0, 4'h1, 24'd3, 24'd4);
    step("pre_rst", 1'b0, 1'b1, 1'b0, 1'b1, 4'h9, 24'hABCDEF, 24'h123456);
    step("reset", 1'b1, 1'b1, 1'b0, 1'b1, 4'h9, 24'hABCDEF, 24'h123456);
    step("resume", 1'b0, 1'b1, 1'b0, 1'b1, 4'h9, 24'hABCDEF, 24'h123456);
    #2; #4 rst = 1'b1;
    #5 rst = 1'b0;
    #1 check("sync_pulse", last);
    #8;
    step("after_pulse", 1'b0, 1'b1, 1'b1, 1'b0, 4'h7, 24'h0F0F0F, 24'hF0F0F0);
    step("width", 1'b0, 1'b1, 1'b0, 1'b1, 4'hF, 24'hFFFFFF, 24'h800001);
    step("rd_wr_both", 1'b0, 1'b0, 1'b1, 1'b1, 4'h3, 24'h000001, 24'h7FFFFF);
    for (int i = 0; i < 6; i++)
      step("random", 1'b0, 1'($urandom), 1'($urandom), 1'($urandom), 4'($urandom),
           24'($urandom), 24'($urandom));
    step("final_rst", 1'b1, 1'b1, 1'b1, 1'b1, 4'hA, 24'h555555, 24'hAAAAAA);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
